data_sram_bridge: RTL and testbench
===================================

Name: data_sram_bridge

Overview:
- Sits directly downstream of the CPU datapath's MEM stage.
- Converts the datapath's single-cycle data-memory request (enable, write-enable, byte select, size, address, store data) into a split-transaction req/addr_ok/data_ok bus.
- Raises stallreq_from_mem while an access is outstanding, and holds returned load data stable until the pipeline advances.
- Guarantees exactly one bus transaction per MEM-stage instruction, including when the pipeline is held by other stall sources or flushed by an exception.

Parameters:
- MAP_KSEG, 1, when 1 kseg0/kseg1 virtual addresses (addr[31:30]==2'b10) map to physical {3'b000, addr[28:0]}; when 0 the address passes unchanged.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- cpu_en  in  1  MEM-stage memory access enable
- cpu_we  in  1  1 = store, 0 = load
- cpu_sel  in  4  byte-lane select of the store
- cpu_size  in  2  0 = byte, 1 = half, 2 = word
- cpu_addr  in  32  virtual address (ALU result)
- cpu_wdata  in  32  lane-aligned store data
- except_flush  in  1  MEM-stage exception pending (excepttype != 0)
- pipe_stall  in  1  MEM stage held this cycle (mem_stall)
- cpu_rdata  out  32  load data returned to the MEM stage
- stallreq_from_mem  out  1  stall request to hazard unit
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_size  out  2  bus size, equal to cpu_size
- data_wstrb  out  4  equals cpu_sel when data_wr=1, else 0
- data_addr  out  32  mapped physical address
- data_wdata  out  32  equals cpu_wdata
- data_addr_ok  in  1  request accepted this cycle
- data_data_ok  in  1  data returned / write done this cycle
- data_rdata  in  32  bus read data

Behaviour:
- State machine has four states: IDLE, REQ, WAIT, DONE. Define start = cpu_en & ~except_flush.
- Reset (async, rst=1):
  - state=IDLE, cancel_r=0, cpu_rdata register=0.
  - data_req=0 and stallreq_from_mem=0 while rst is high.
- IDLE:
  - data_req = start.
  - start & data_addr_ok → WAIT; start & ~data_addr_ok → REQ; otherwise stay in IDLE.
- REQ:
  - data_req=1.
  - except_flush → IDLE; data_req drops that cycle and the request is abandoned.
  - else data_addr_ok → WAIT.
- WAIT:
  - data_req=0.
  - except_flush sets cancel_r.
  - On data_data_ok: if cancel_r|except_flush → IDLE, cancel_r cleared, data discarded. Else capture data_rdata into cpu_rdata and go to DONE.
- DONE:
  - No bus activity.
  - ~pipe_stall → IDLE; else stay. The held instruction is never re-issued.
  - except_flush in DONE → IDLE.
- stallreq_from_mem = (IDLE & start) | REQ | WAIT. It is 0 in DONE, so it deasserts the cycle after data_ok.
  - Best-case load latency: 2 cycles of stall, with addr_ok in the issue cycle and data_ok on the next cycle.
- An accepted transaction is never cancelled. stallreq stays high in WAIT even under except_flush until data_ok.
- Bus rule: data_data_ok never arrives in the same cycle as its own data_addr_ok; it arrives no earlier than the following cycle. At most one transaction is outstanding.
- data_addr, data_wr, data_size, data_wdata and data_wstrb are combinational from the cpu_* inputs, which the stalled pipeline holds stable while stallreq is high.
- cpu_rdata is a register; it changes only on a non-cancelled data_ok.
- Stores follow the same FSM; cpu_rdata is left unchanged by a store's data_ok (captured only when ~cpu_we).

Test Plan:
- Load, addr 0x8000_1004, size=2:
  - Bus: addr_ok in issue cycle, data_ok 2 cycles later with 0xDEADBEEF.
  - Required: data_addr=0x0000_1004, data_req high exactly 1 cycle, stallreq high 3 cycles, cpu_rdata=0xDEADBEEF from the next cycle, state DONE.
- Store byte, sel=4'b0100, wdata=0x00AB0000, addr_ok delayed 3 cycles:
  - Required: data_req high 4 cycles, data_wr=1, data_wstrb=4'b0100, cpu_rdata unchanged after data_ok.
- Load completes with pipe_stall held 5 more cycles (IF stall):
  - Required: no second data_req, stallreq=0 throughout, cpu_rdata stable; IDLE the cycle after pipe_stall falls.
- except_flush in REQ before addr_ok:
  - Required: data_req=0 the same cycle, stallreq=0, IDLE, no transaction accepted.
- except_flush in WAIT:
  - Required: stallreq stays 1 until data_ok (0x12345678); cpu_rdata retains its old value; IDLE next cycle.
- MAP_KSEG=0, addr 0xA000_0010:
  - Required: data_addr=0xA000_0010.
- rst asserted mid-WAIT:
  - Required: immediate IDLE, data_req=0, stallreq=0, cpu_rdata=0.

Source files
------------

// File: rtl/data_sram_bridge.sv
// MEM-stage to split-transaction SRAM bus bridge: one bus transaction per MEM instruction,
// stalls the pipeline while outstanding and holds load data until the pipeline advances.
module data_sram_bridge #(
  parameter bit MAP_KSEG = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_sel,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        except_flush,
  input  logic        pipe_stall,
  output logic [31:0] cpu_rdata,
  output logic        stallreq_from_mem,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic        cancel_r, cancel_nxt;
  logic        capture;
  logic        req, stall;
  logic [31:0] rdata_r;
  logic        start;

  assign start = cpu_en & ~except_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cancel_r <= 1'b0;
      rdata_r  <= '0;
    end else begin
      state    <= state_nxt;
      cancel_r <= cancel_nxt;
      if (capture) rdata_r <= data_rdata;
    end
  end

  always_comb begin
    state_nxt  = state;
    cancel_nxt = cancel_r;
    capture    = 1'b0;
    req        = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        req   = start;
        stall = start;
        if (start) state_nxt = data_addr_ok ? WAIT : REQ;
      end
      REQ: begin
        // a flush before acceptance abandons the request outright
        stall = 1'b1;
        req   = ~except_flush;
        if (except_flush)      state_nxt = IDLE;
        else if (data_addr_ok) state_nxt = WAIT;
      end
      WAIT: begin
        // accepted transactions must drain; a flush only marks the result as discarded
        stall = 1'b1;
        if (data_data_ok) begin
          if (cancel_r | except_flush) begin
            state_nxt  = IDLE;
            cancel_nxt = 1'b0;
          end else begin
            capture   = ~cpu_we;
            state_nxt = DONE;
          end
        end else if (except_flush) begin
          cancel_nxt = 1'b1;
        end
      end
      DONE: begin
        if (except_flush | ~pipe_stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign data_req          = req & ~rst;
  assign stallreq_from_mem = stall & ~rst;
  assign cpu_rdata         = rdata_r;

  assign data_wr    = cpu_we;
  assign data_size  = cpu_size;
  assign data_wstrb = cpu_we ? cpu_sel : 4'b0000;
  assign data_wdata = cpu_wdata;
  assign data_addr  = (MAP_KSEG && cpu_addr[31:30] == 2'b10) ? {3'b000, cpu_addr[28:0]}
                                                             : cpu_addr;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed bench for data_sram_bridge: load/store, pipeline hold, flush, address map, reset.
module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_en = 1'b0, cpu_we = 1'b0;
  logic [3:0]  cpu_sel = '0;
  logic [1:0]  cpu_size = '0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        except_flush = 1'b0, pipe_stall = 1'b0;
  logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
  logic [31:0] data_rdata = '0;

  logic [31:0] cpu_rdata, data_addr, data_wdata;
  logic        stallreq_from_mem, data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;

  logic [31:0] n_cpu_rdata, n_data_addr, n_data_wdata;
  logic        n_stall, n_req, n_wr;
  logic [1:0]  n_size;
  logic [3:0]  n_wstrb;

  int chk_cnt = 0, pass_cnt = 0;
  int req_cnt = 0, stall_cnt = 0, acc_cnt = 0;
  int req_b, stall_b, acc_b;

  always #5 clk = ~clk;

  data_sram_bridge #(.MAP_KSEG(1'b1)) dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_sel(cpu_sel),
    .cpu_size(cpu_size), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .except_flush(except_flush), .pipe_stall(pipe_stall), .cpu_rdata(cpu_rdata),
    .stallreq_from_mem(stallreq_from_mem), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata));

  data_sram_bridge #(.MAP_KSEG(1'b0)) dut_nomap (
    .clk(clk), .rst(rst), .cpu_en(1'b0), .cpu_we(cpu_we), .cpu_sel(cpu_sel),
    .cpu_size(cpu_size), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .except_flush(1'b0), .pipe_stall(1'b0), .cpu_rdata(n_cpu_rdata),
    .stallreq_from_mem(n_stall), .data_req(n_req), .data_wr(n_wr),
    .data_size(n_size), .data_wstrb(n_wstrb), .data_addr(n_data_addr),
    .data_wdata(n_data_wdata), .data_addr_ok(1'b0), .data_data_ok(1'b0),
    .data_rdata(32'h0));

  always @(posedge clk) begin
    if (!rst) begin
      if (data_req) req_cnt++;
      if (stallreq_from_mem) stall_cnt++;
      if (data_req && data_addr_ok) acc_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic snap();
    req_b = req_cnt; stall_b = stall_cnt; acc_b = acc_cnt;
  endtask

  task automatic bus_idle();
    cpu_en = 0; cpu_we = 0; except_flush = 0; pipe_stall = 0;
    data_addr_ok = 0; data_data_ok = 0;
  endtask

  task automatic test_reset();
    rst = 1; cpu_en = 1; #3;
    chk_cnt++;
    if (data_req !== 1'b0 || stallreq_from_mem !== 1'b0 || cpu_rdata !== 32'h0)
      $display("FAIL reset: req=%b stall=%b rdata=%h, expected 0/0/0", data_req, stallreq_from_mem, cpu_rdata);
    else pass_cnt++;
    cyc(); cpu_en = 0; rst = 0; cyc();
  endtask

  task automatic test_load();
    cyc(); snap();
    cpu_en = 1; cpu_we = 0; cpu_size = 2; cpu_addr = 32'h8000_1004; data_addr_ok = 1; #3;
    chk_cnt++;
    if (data_addr !== 32'h0000_1004 || data_req !== 1'b1 || stallreq_from_mem !== 1'b1)
      $display("FAIL load_issue: addr=%h req=%b stall=%b, expected 00001004/1/1", data_addr, data_req, stallreq_from_mem);
    else pass_cnt++;
    cyc(); data_addr_ok = 0;
    cyc(); data_data_ok = 1; data_rdata = 32'hDEAD_BEEF;
    cyc(); data_data_ok = 0; data_rdata = 32'h0; #3;
    chk_cnt++;
    if (cpu_rdata !== 32'hDEAD_BEEF || stallreq_from_mem !== 1'b0 || data_req !== 1'b0)
      $display("FAIL load_done: rdata=%h stall=%b req=%b, expected deadbeef/0/0", cpu_rdata, stallreq_from_mem, data_req);
    else pass_cnt++;
    chk_cnt++;
    if (req_cnt - req_b !== 1 || stall_cnt - stall_b !== 3)
      $display("FAIL load_counts: req_cycles=%0d stall_cycles=%0d, expected 1/3", req_cnt - req_b, stall_cnt - stall_b);
    else pass_cnt++;
    cpu_en = 0; cyc();
  endtask

  task automatic test_store();
    cyc(); snap();
    cpu_en = 1; cpu_we = 1; cpu_size = 0; cpu_sel = 4'b0100;
    cpu_addr = 32'h0000_0102; cpu_wdata = 32'h00AB_0000; #3;
    chk_cnt++;
    if (data_wr !== 1'b1 || data_wstrb !== 4'b0100 || data_wdata !== 32'h00AB_0000 || data_size !== 2'd0)
      $display("FAIL store_bus: wr=%b wstrb=%b wdata=%h size=%0d, expected 1/0100/00ab0000/0", data_wr, data_wstrb, data_wdata, data_size);
    else pass_cnt++;
    cyc(); cyc(); cyc(); data_addr_ok = 1;
    cyc(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h5A5A_5A5A;
    cyc(); data_data_ok = 0; #3;
    chk_cnt++;
    if (cpu_rdata !== 32'hDEAD_BEEF || req_cnt - req_b !== 4)
      $display("FAIL store_done: rdata=%h req_cycles=%0d, expected deadbeef/4", cpu_rdata, req_cnt - req_b);
    else pass_cnt++;
    cpu_en = 0; cpu_we = 0; cpu_sel = 0; cyc();
  endtask

  task automatic test_pipe_hold();
    int bad = 0;
    cyc(); snap();
    cpu_en = 1; cpu_we = 0; cpu_size = 2; cpu_addr = 32'h0000_2000; data_addr_ok = 1;
    cyc(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h0BAD_F00D;
    cyc(); data_data_ok = 0; pipe_stall = 1; #3;
    chk_cnt++;
    if (stall_cnt - stall_b !== 2)
      $display("FAIL best_case_stall: stall_cycles=%0d, expected 2", stall_cnt - stall_b);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) pipe_stall = 0;
      #1;
      if (stallreq_from_mem !== 1'b0 || data_req !== 1'b0 || cpu_rdata !== 32'h0BAD_F00D) bad++;
      cyc();
    end
    chk_cnt++;
    if (bad != 0)
      $display("FAIL hold_stable: bad_cycles=%0d, expected 0", bad);
    else pass_cnt++;
    data_addr_ok = 1; #3;
    chk_cnt++;
    if (data_req !== 1'b1 || req_cnt - req_b !== 1)
      $display("FAIL hold_reissue: req=%b prior_req_cycles=%0d, expected 1/1", data_req, req_cnt - req_b);
    else pass_cnt++;
    cyc(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h1111_2222;
    cyc(); data_data_ok = 0; cpu_en = 0; cyc();
  endtask

  task automatic test_flush_req();
    cyc(); snap();
    cpu_en = 1; cpu_we = 0; cpu_addr = 32'h0000_3000;
    cyc(); except_flush = 1; #3;
    chk_cnt++;
    if (data_req !== 1'b0)
      $display("FAIL flush_req_same: req=%b, expected 0", data_req);
    else pass_cnt++;
    cyc(); except_flush = 0; cpu_en = 0; #3;
    chk_cnt++;
    if (data_req !== 1'b0 || stallreq_from_mem !== 1'b0 || acc_cnt - acc_b !== 0)
      $display("FAIL flush_req_after: req=%b stall=%b accepted=%0d, expected 0/0/0", data_req, stallreq_from_mem, acc_cnt - acc_b);
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_flush_wait();
    int bad = 0;
    cyc();
    cpu_en = 1; cpu_we = 0; cpu_addr = 32'h0000_4000; data_addr_ok = 1;
    cyc(); data_addr_ok = 0; except_flush = 1; #1;
    if (stallreq_from_mem !== 1'b1) bad++;
    cyc(); except_flush = 0; cpu_en = 0; #1;
    if (stallreq_from_mem !== 1'b1 || data_req !== 1'b0) bad++;
    cyc(); data_data_ok = 1; data_rdata = 32'h1234_5678; #1;
    if (stallreq_from_mem !== 1'b1) bad++;
    chk_cnt++;
    if (bad != 0) $display("FAIL flush_wait_stall: bad_cycles=%0d, expected 0", bad);
    else pass_cnt++;
    cyc(); data_data_ok = 0; data_rdata = 0; cpu_en = 1; cpu_addr = 32'h0000_4004; data_addr_ok = 1; #3;
    chk_cnt++;
    if (cpu_rdata !== 32'h1111_2222 || data_req !== 1'b1)
      $display("FAIL flush_wait_discard: rdata=%h req=%b, expected 11112222/1", cpu_rdata, data_req);
    else pass_cnt++;
    cyc(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h5555_6666;
    cyc(); data_data_ok = 0; #3;
    chk_cnt++;
    if (cpu_rdata !== 32'h5555_6666)
      $display("FAIL after_flush_load: rdata=%h, expected 55556666", cpu_rdata);
    else pass_cnt++;
    cpu_en = 0; cyc();
  endtask

  task automatic test_flush_on_data_ok();
    cyc();
    cpu_en = 1; cpu_addr = 32'h0000_5000; data_addr_ok = 1;
    cyc(); data_addr_ok = 0; data_data_ok = 1; except_flush = 1; data_rdata = 32'h7777_8888;
    cyc(); data_data_ok = 0; except_flush = 0; cpu_en = 0; #3;
    chk_cnt++;
    if (cpu_rdata !== 32'h5555_6666 || stallreq_from_mem !== 1'b0)
      $display("FAIL flush_on_data_ok: rdata=%h stall=%b, expected 55556666/0", cpu_rdata, stallreq_from_mem);
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_addr_map();
    cpu_addr = 32'hA000_0010; #2;
    chk_cnt++;
    if (n_data_addr !== 32'hA000_0010 || data_addr !== 32'h0000_0010)
      $display("FAIL addr_map: nomap=%h map=%h, expected a0000010/00000010", n_data_addr, data_addr);
    else pass_cnt++;
    cpu_addr = 32'h4000_0020; #2;
    chk_cnt++;
    if (data_addr !== 32'h4000_0020)
      $display("FAIL addr_useg: map=%h, expected 40000020", data_addr);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_wait();
    cyc();
    cpu_en = 1; cpu_addr = 32'h0000_6000; data_addr_ok = 1;
    cyc(); data_addr_ok = 0; rst = 1; #1;
    chk_cnt++;
    if (data_req !== 1'b0 || stallreq_from_mem !== 1'b0 || cpu_rdata !== 32'h0)
      $display("FAIL reset_mid_wait: req=%b stall=%b rdata=%h, expected 0/0/0", data_req, stallreq_from_mem, cpu_rdata);
    else pass_cnt++;
    #1 rst = 0; #1;
    chk_cnt++;
    if (data_req !== 1'b1 || stallreq_from_mem !== 1'b1)
      $display("FAIL reset_to_idle: req=%b stall=%b, expected 1/1", data_req, stallreq_from_mem);
    else pass_cnt++;
    cpu_en = 0; cyc();
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_load();
    test_store();
    test_pipe_hold();
    test_flush_req();
    test_flush_wait();
    test_flush_on_data_ok();
    test_addr_map();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
